// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decryption: one shared inverse-round datapath is stepped through rounds 9..0.
// Round keys come from an external expanded-key store, addressed by index.

module decrypt_round (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         is_final_round_i,
  output logic [127:0] state_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    end
    return gf_inv(t ^ 8'h05);
  endfunction

  logic [127:0] added;
  logic [127:0] mixed;

  // Byte i sits at row i%4, column i/4; InvShiftRows takes row r from column (c - r) mod 4.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    added = '0;
    for (int i = 0; i < 16; i++) begin
      added[127 - 8*i -: 8] = inv_sbox(state_i[127 - 8*((i % 4) + 4*(((i / 4) - (i % 4) + 4) % 4)) -: 8])
                              ^ key_i[127 - 8*i -: 8];
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 8] = gf_mul(added[127 - 32*c -: 8], 8'h0e) ^ gf_mul(added[119 - 32*c -: 8], 8'h0b)
                             ^ gf_mul(added[111 - 32*c -: 8], 8'h0d) ^ gf_mul(added[103 - 32*c -: 8], 8'h09);
      mixed[119 - 32*c -: 8] = gf_mul(added[127 - 32*c -: 8], 8'h09) ^ gf_mul(added[119 - 32*c -: 8], 8'h0e)
                             ^ gf_mul(added[111 - 32*c -: 8], 8'h0b) ^ gf_mul(added[103 - 32*c -: 8], 8'h0d);
      mixed[111 - 32*c -: 8] = gf_mul(added[127 - 32*c -: 8], 8'h0d) ^ gf_mul(added[119 - 32*c -: 8], 8'h09)
                             ^ gf_mul(added[111 - 32*c -: 8], 8'h0e) ^ gf_mul(added[103 - 32*c -: 8], 8'h0b);
      mixed[103 - 32*c -: 8] = gf_mul(added[127 - 32*c -: 8], 8'h0b) ^ gf_mul(added[119 - 32*c -: 8], 8'h0d)
                             ^ gf_mul(added[111 - 32*c -: 8], 8'h09) ^ gf_mul(added[103 - 32*c -: 8], 8'h0e);
    end
  end

  assign state_o = is_final_round_i ? added : mixed;

endmodule

module aes_decrypt_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

  localparam logic [3:0] LAST_KEY = 4'd10;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic [127:0] round_out;

  decrypt_round u_round (
    .state_i          (data_q),
    .key_i            (rk_data_i),
    .is_final_round_i (rnd_q == 4'd0),
    .state_o          (round_out)
  );

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst_i) begin
      fsm_q  <= S_IDLE;
      rnd_q  <= '0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    data_d      = data_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    rk_idx_o    = LAST_KEY;
    unique case (fsm_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          data_d = in_data_i ^ rk_data_i;
          rnd_d  = 4'd9;
          fsm_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        busy_o   = 1'b1;
        rk_idx_o = rnd_q;
        data_d   = round_out;
        if (rnd_q == 4'd0) fsm_d = S_DONE;
        else               rnd_d = rnd_q - 4'd1;
      end
      S_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign out_data_o = data_q;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed bench for aes_decrypt_ctrl using the FIPS-197 C.1 AES-128 vector and a modelled key store.

module tb_aes_decrypt_ctrl;

  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic [127:0] rk_tab [11];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rk_data = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  aes_decrypt_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .rk_idx_o    (rk_idx),
    .rk_data_i   (rk_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rk_idx"}, rk_idx, 10);
  endtask

  // Starts in IDLE just after an edge; returns in IDLE after the output handshake.
  task automatic run_block(input string tag, input int hold, input bit stall);
    check({tag, "_accept_ready"}, in_ready, 1);
    check({tag, "_idle_rk_idx"}, rk_idx, 10);
    in_valid = 1'b1;
    in_data  = CT;
    step();
    in_valid = 1'b0;
    in_data  = rand128();
    for (int r = 9; r >= 0; r--) begin
      check($sformatf("%s_rk_idx_r%0d", tag, r), rk_idx, r);
      check($sformatf("%s_busy_r%0d", tag, r), busy, 1);
      check($sformatf("%s_in_ready_r%0d", tag, r), in_ready, 0);
      check($sformatf("%s_out_valid_r%0d", tag, r), out_valid, 0);
      in_valid = stall && (r == 5 || r == 4);
      in_data  = rand128();
      step();
    end
    in_valid = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_out_data"}, out_data, PT);
    check({tag, "_done_rk_idx"}, rk_idx, 10);
    for (int h = 0; h < hold; h++) begin
      step();
      check($sformatf("%s_hold%0d_valid", tag, h), out_valid, 1);
      check($sformatf("%s_hold%0d_data", tag, h), out_data, PT);
      check($sformatf("%s_hold%0d_in_ready", tag, h), in_ready, 0);
      check($sformatf("%s_hold%0d_busy", tag, h), busy, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
    int acc;
    int outs;
    int acc_cyc [2];

    rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    rst       = 1'b1;
    in_valid  = 1'($urandom);
    in_data   = rand128();
    out_ready = 1'($urandom);
    step();
    in_valid  = 1'($urandom);
    in_data   = rand128();
    out_ready = 1'($urandom);
    step();
    check_idle("reset");
    check("reset_out_data", out_data, '0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    run_block("c1", 0, 1'b0);
    run_block("bp", 20, 1'b0);
    run_block("stall", 0, 1'b1);

    // Ready held high while idle-state out_ready is ignored; then a mid-round reset.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = CT;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("midrst_rk_idx_t5", rk_idx, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_out_data", out_data, '0);
    run_block("post_rst", 0, 1'b0);

    // Back-to-back with both handshakes always offered.
    acc = 0;
    outs = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = CT;
    for (int c = 0; c < 40 && outs < 2; c++) begin
      if (in_ready && in_valid && acc < 2) begin
        acc_cyc[acc] = c;
        acc++;
      end
      if (out_valid && out_ready) begin
        check($sformatf("b2b_out%0d", outs), out_data, PT);
        outs++;
      end
      step();
      if (acc == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", acc, 2);
    check("b2b_outputs", outs, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 12);
    check_idle("b2b_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
